// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution input path.
package conv_pkg;

    localparam int PIX_PER_WORD = 3;
    localparam int COORD_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        DONE
    } loader_state_t;

endpackage

// File: rtl/conv_pixel_packer.sv
// Collects three consecutive pixel beats into one packed word {p2, p1, p0}.
module conv_pixel_packer
    import conv_pkg::*;
#(
    parameter int MEM_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              arst_n_in,
    input  logic                              beat,
    input  logic [MEM_WIDTH-1:0]              pix_data,
    input  logic                              clr,
    output logic                              word_valid,
    output logic [PIX_PER_WORD*MEM_WIDTH-1:0] word
);

    localparam logic [1:0] LANE_LAST = 2'(PIX_PER_WORD - 1);

    logic [1:0]           lane_reg;
    logic [MEM_WIDTH-1:0] p0_reg;
    logic [MEM_WIDTH-1:0] p1_reg;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            lane_reg <= '0;
            p0_reg   <= '0;
            p1_reg   <= '0;
        end else if (clr) begin
            lane_reg <= '0;
            p0_reg   <= '0;
            p1_reg   <= '0;
        end else if (beat) begin
            case (lane_reg)
                2'd0: begin
                    p0_reg   <= pix_data;
                    lane_reg <= 2'd1;
                end
                2'd1: begin
                    p1_reg   <= pix_data;
                    lane_reg <= 2'd2;
                end
                default: lane_reg <= '0;
            endcase
        end
    end

    // The third pixel is taken straight from the input; the loader registers the word.
    assign word_valid = beat && (lane_reg == LANE_LAST);
    assign word       = {pix_data, p1_reg, p0_reg};

endmodule

// File: rtl/conv_input_loader.sv
// Loads a raster pixel stream into the input-feature-map buffer, three pixels per write,
// clearing the buffer first and reporting row progress to the window reader.
module conv_input_loader
    import conv_pkg::*;
#(
    parameter int MEM_WIDTH  = 16,
    parameter int IMG_WIDTH  = 63,
    parameter int IMG_HEIGHT = 128
) (
    input  logic                              clk,
    input  logic                              arst_n_in,
    input  logic                              start,
    input  logic                              pix_valid,
    input  logic [MEM_WIDTH-1:0]              pix_data,
    output logic                              pix_ready,
    output logic                              write_en,
    output logic [PIX_PER_WORD*MEM_WIDTH-1:0] din,
    output logic [COORD_W-1:0]                x_write,
    output logic [COORD_W-1:0]                y_write,
    output logic                              mem_rst,
    output logic                              busy,
    output logic                              row_done,
    output logic [COORD_W-1:0]                rows_loaded,
    output logic                              done
);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMG_WIDTH - PIX_PER_WORD);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] ROWS_MAX = '1;

    loader_state_t state_reg, state_next;

    logic [COORD_W-1:0]                x_reg, y_reg, rows_reg;
    logic [PIX_PER_WORD*MEM_WIDTH-1:0] din_reg;
    logic [COORD_W-1:0]                x_write_reg, y_write_reg;
    logic                              write_en_reg, row_done_reg;

    logic                              beat, clr, word_valid, row_end, last_word;
    logic [PIX_PER_WORD*MEM_WIDTH-1:0] word;

    assign beat      = pix_valid && pix_ready;
    assign clr       = (state_reg == IDLE) && start;
    assign row_end   = (x_reg == X_LAST);
    assign last_word = row_end && (y_reg == Y_LAST);

    conv_pixel_packer #(
        .MEM_WIDTH(MEM_WIDTH)
    ) u_packer (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .beat      (beat),
        .pix_data  (pix_data),
        .clr       (clr),
        .word_valid(word_valid),
        .word      (word)
    );

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Control outputs are decoded from the state register only, never from inputs.
    always_comb begin
        state_next = state_reg;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        mem_rst    = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                mem_rst    = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (word_valid && last_word) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            x_reg        <= '0;
            y_reg        <= '0;
            rows_reg     <= '0;
            din_reg      <= '0;
            x_write_reg  <= '0;
            y_write_reg  <= '0;
            write_en_reg <= 1'b0;
            row_done_reg <= 1'b0;
        end else begin
            write_en_reg <= word_valid;
            row_done_reg <= word_valid && row_end;
            if (clr) begin
                x_reg    <= '0;
                y_reg    <= '0;
                rows_reg <= '0;
            end else if (word_valid) begin
                din_reg     <= word;
                x_write_reg <= x_reg;
                y_write_reg <= y_reg;
                if (row_end) begin
                    x_reg <= '0;
                    y_reg <= y_reg + 1'b1;
                    if (rows_reg != ROWS_MAX) rows_reg <= rows_reg + 1'b1;
                end else begin
                    x_reg <= x_reg + COORD_W'(PIX_PER_WORD);
                end
            end
        end
    end

    assign write_en    = write_en_reg;
    assign din         = din_reg;
    assign x_write     = x_write_reg;
    assign y_write     = y_write_reg;
    assign row_done    = row_done_reg;
    assign rows_loaded = rows_reg;

endmodule

// File: tb/tb_conv_input_loader.sv
// Bench: a 6x2 and a default 63x128 loader checked every cycle against a pixel-index model.
module tb_conv_input_loader;

    localparam int MW = 16;
    localparam int W0 = 6;
    localparam int H0 = 2;
    localparam int W1 = 63;
    localparam int H1 = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_n, start, pix_valid;
    logic [1:0]    pix_ready, write_en, mem_rst, busy, row_done, done;
    logic [MW-1:0] pix_data [2];
    logic [47:0]   din [2];
    logic [7:0]    x_write [2];
    logic [7:0]    y_write [2];
    logic [7:0]    rows_loaded [2];

    conv_input_loader #(.MEM_WIDTH(MW), .IMG_WIDTH(W0), .IMG_HEIGHT(H0)) dut_small (
        .clk(clk), .arst_n_in(rst_n[0]), .start(start[0]), .pix_valid(pix_valid[0]),
        .pix_data(pix_data[0]), .pix_ready(pix_ready[0]), .write_en(write_en[0]),
        .din(din[0]), .x_write(x_write[0]), .y_write(y_write[0]), .mem_rst(mem_rst[0]),
        .busy(busy[0]), .row_done(row_done[0]), .rows_loaded(rows_loaded[0]), .done(done[0])
    );

    conv_input_loader #(.MEM_WIDTH(MW), .IMG_WIDTH(W1), .IMG_HEIGHT(H1)) dut_full (
        .clk(clk), .arst_n_in(rst_n[1]), .start(start[1]), .pix_valid(pix_valid[1]),
        .pix_data(pix_data[1]), .pix_ready(pix_ready[1]), .write_en(write_en[1]),
        .din(din[1]), .x_write(x_write[1]), .y_write(y_write[1]), .mem_rst(mem_rst[1]),
        .busy(busy[1]), .row_done(row_done[1]), .rows_loaded(rows_loaded[1]), .done(done[1])
    );

    // Expected outputs, derived from the count k of pixels accepted since start.
    int          k [2];
    logic [15:0] hold [2][3];
    bit          e_we [2], e_mem_rst [2], e_ready [2], e_busy [2], e_row_done [2], e_done [2];
    logic [47:0] e_din [2];
    int          e_x [2], e_y [2], e_rows [2];
    bit          consumed [2];

    int vmode [2], dmode [2], sq [2];

    int tests = 0;
    int fails = 0;

    typedef struct { logic [47:0] d; int x; int y; bit rd; bit dn; } wr_t;
    wr_t wq [$];
    int  wr_count [2], memrst_cnt [2], b2b [2], busy_cyc [2], last_x [2], last_y [2];
    bit  last_done [2], prev_we [2];

    logic [47:0] lit_d [4] = '{48'h0003_0002_0001, 48'h0006_0005_0004,
                               48'h0009_0008_0007, 48'h000c_000b_000a};
    int lit_x [4] = '{0, 3, 0, 3};
    int lit_y [4] = '{0, 0, 1, 1};
    bit lit_rd [4] = '{0, 1, 0, 1};
    bit lit_dn [4] = '{0, 0, 0, 1};

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit beat, pm, pd;
            int w, wpr, iw, ih;
            iw   = (i == 0) ? W0 : W1;
            ih   = (i == 0) ? H0 : H1;
            beat = pix_valid[i] && e_ready[i];
            if (!rst_n[i]) begin
                k[i] = 0; consumed[i] = 0;
                e_we[i] = 0; e_mem_rst[i] = 0; e_ready[i] = 0; e_busy[i] = 0;
                e_row_done[i] = 0; e_done[i] = 0; e_din[i] = '0;
                e_x[i] = 0; e_y[i] = 0; e_rows[i] = 0;
                continue;
            end
            pm = e_mem_rst[i];
            pd = e_done[i];
            e_we[i] = 0; e_row_done[i] = 0; e_done[i] = 0; e_mem_rst[i] = 0;
            consumed[i] = beat;
            if (pm) e_ready[i] = 1;
            else if (pd) e_busy[i] = 0;
            else if (!e_busy[i] && start[i]) begin
                e_mem_rst[i] = 1; e_busy[i] = 1; k[i] = 0; e_rows[i] = 0;
            end
            if (beat) begin
                hold[i][k[i] % 3] = pix_data[i];
                k[i]++;
                if (k[i] % 3 == 0) begin
                    w   = k[i] / 3 - 1;
                    wpr = iw / 3;
                    e_we[i]       = 1;
                    e_din[i]      = {hold[i][2], hold[i][1], hold[i][0]};
                    e_x[i]        = (w % wpr) * 3;
                    e_y[i]        = w / wpr;
                    e_row_done[i] = (k[i] % iw == 0);
                    e_rows[i]     = (k[i] / iw > 255) ? 255 : k[i] / iw;
                    if (k[i] == iw * ih) begin
                        e_done[i]  = 1;
                        e_ready[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            chk("pix_ready", i, 64'(pix_ready[i]), 64'(e_ready[i]));
            chk("write_en", i, 64'(write_en[i]), 64'(e_we[i]));
            chk("mem_rst", i, 64'(mem_rst[i]), 64'(e_mem_rst[i]));
            chk("busy", i, 64'(busy[i]), 64'(e_busy[i]));
            chk("row_done", i, 64'(row_done[i]), 64'(e_row_done[i]));
            chk("done", i, 64'(done[i]), 64'(e_done[i]));
            chk("rows_loaded", i, 64'(rows_loaded[i]), 64'(e_rows[i]));
            chk("din", i, 64'(din[i]), 64'(e_din[i]));
            chk("x_write", i, 64'(x_write[i]), 64'(8'(e_x[i])));
            chk("y_write", i, 64'(y_write[i]), 64'(8'(e_y[i])));
            if (write_en[i] === 1'b1) begin
                wr_count[i]++;
                last_x[i] = int'(x_write[i]);
                last_y[i] = int'(y_write[i]);
                last_done[i] = done[i];
                if (prev_we[i]) b2b[i]++;
                if (i == 0) wq.push_back('{din[i], int'(x_write[i]), int'(y_write[i]), row_done[i], done[i]});
                $display("[TB] inst%0d write x=%0d y=%0d din=%012h row_done=%0b done=%0b",
                         i, x_write[i], y_write[i], din[i], row_done[i], done[i]);
            end
            prev_we[i] = (write_en[i] === 1'b1);
            if (mem_rst[i] === 1'b1) memrst_cnt[i]++;
            if (busy[i] === 1'b1) busy_cyc[i]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (consumed[i]) begin
                sq[i]++;
                pix_data[i] = (dmode[i] != 0) ? 16'($urandom) : 16'(sq[i] + 1);
            end
            case (vmode[i])
                0:       pix_valid[i] = 1'b0;
                1:       pix_valid[i] = 1'b1;
                2:       pix_valid[i] = ~pix_valid[i];
                default: pix_valid[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic run_frame(input int i, input int vm, input int dm, input int extra_start, input int abort_after);
        wr_count[i] = 0; memrst_cnt[i] = 0; b2b[i] = 0; busy_cyc[i] = 0;
        if (i == 0) wq.delete();
        sq[i] = 0;
        dmode[i] = dm;
        pix_data[i] = (dm != 0) ? 16'($urandom) : 16'd1;
        vmode[i] = vm;
        pix_valid[i] = (vm != 0);
        start[i] = 1'b1;
        cyc();
        start[i] = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (!e_busy[i]) break;
            start[i] = (n == extra_start);
            if (abort_after >= 0 && k[i] >= abort_after) begin
                rst_n[i] = 1'b0;
                cyc();
                chk("no_write_in_reset", i, 64'(write_en[i]), 64'd0);
                cyc();
                rst_n[i] = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        start[i] = 1'b0;
        chk("busy_after_frame", i, 64'(busy[i]), 64'd0);
        vmode[i] = (i == 1) ? 1 : 0;
    endtask

    task automatic check_small_literals(input string tag);
        chk({tag, "_mem_rst_cnt"}, 0, 64'(memrst_cnt[0]), 64'd1);
        chk({tag, "_wr_cnt"}, 0, 64'(wq.size()), 64'd4);
        chk({tag, "_rows"}, 0, 64'(rows_loaded[0]), 64'd2);
        for (int j = 0; j < 4 && j < wq.size(); j++) begin
            chk({tag, "_din"}, 0, 64'(wq[j].d), 64'(lit_d[j]));
            chk({tag, "_x"}, 0, 64'(wq[j].x), 64'(lit_x[j]));
            chk({tag, "_y"}, 0, 64'(wq[j].y), 64'(lit_y[j]));
            chk({tag, "_row_done"}, 0, 64'(wq[j].rd), 64'(lit_rd[j]));
            chk({tag, "_done"}, 0, 64'(wq[j].dn), 64'(lit_dn[j]));
        end
    endtask

    initial begin
        rst_n = 2'b00; start = 2'b00; pix_valid = 2'b00;
        pix_data[0] = '0; pix_data[1] = '0;
        for (int i = 0; i < 2; i++) begin
            vmode[i] = 0; dmode[i] = 0; sq[i] = 0; consumed[i] = 0; prev_we[i] = 0;
            k[i] = 0; e_we[i] = 0; e_mem_rst[i] = 0; e_ready[i] = 0; e_busy[i] = 0;
            e_row_done[i] = 0; e_done[i] = 0; e_din[i] = '0; e_x[i] = 0; e_y[i] = 0; e_rows[i] = 0;
            wr_count[i] = 0; memrst_cnt[i] = 0; b2b[i] = 0; busy_cyc[i] = 0;
            last_x[i] = 0; last_y[i] = 0; last_done[i] = 0;
        end
        repeat (3) cyc();
        rst_n = 2'b11;
        vmode[1] = 1;
        repeat (3) cyc();

        run_frame(0, 1, 0, -1, -1);
        check_small_literals("b2b");
        chk("b2b_busy_cycles", 0, 64'(busy_cyc[0]), 64'd14);

        run_frame(0, 2, 0, -1, -1);
        check_small_literals("gaps");
        chk("gaps_no_back_to_back", 0, 64'(b2b[0]), 64'd0);

        run_frame(0, 1, 0, 5, -1);
        check_small_literals("restart");

        run_frame(0, 1, 0, -1, 4);
        chk("abort_busy", 0, 64'(busy[0]), 64'd0);
        chk("abort_rows", 0, 64'(rows_loaded[0]), 64'd0);
        run_frame(0, 1, 0, -1, -1);
        check_small_literals("after_abort");

        for (int r = 0; r < 3; r++) run_frame(0, 3, 1, -1, -1);

        run_frame(1, 1, 0, -1, -1);
        chk("full_wr_cnt", 1, 64'(wr_count[1]), 64'd2688);
        chk("full_last_x", 1, 64'(last_x[1]), 64'd60);
        chk("full_last_y", 1, 64'(last_y[1]), 64'd127);
        chk("full_last_done", 1, 64'(last_done[1]), 64'd1);
        chk("full_rows", 1, 64'(rows_loaded[1]), 64'd128);
        chk("full_busy_cycles", 1, 64'(busy_cyc[1]), 64'd8066);

        repeat (4) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
